// File: rtl/audio_pkg.sv
// Shared constants and types for the audio Pmod serial paths.
// Frame: 512 clocks, 32 slots of 16 clocks, one-bit I2S delay.
package audio_pkg;
    localparam int AUDIO_W = 16;
    localparam int SLOT_CNT = 32;
    localparam logic [3:0] SAMPLE_PHASE = 4'hD;
    localparam logic [4:0] SLOT_RLSB = 5'd0;
    localparam logic [4:0] SLOT_LMSB = 5'd1;
    localparam logic [4:0] SLOT_RMSB = 5'd17;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } pair_t;

    // |x| with -32768 saturated to 32767
    function automatic logic [AUDIO_W-2:0] sat_abs(input sample_t x);
        if (x[AUDIO_W-1] && x[AUDIO_W-2:0] == '0)
            return '1;
        return x[AUDIO_W-1] ? (AUDIO_W-1)'(-x) : x[AUDIO_W-2:0];
    endfunction
endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter producing the I2S clocks, slot index
// and the once-per-slot sample strobe.
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       mclk_o,
    output logic       lrck_o,
    output logic       sck_o,
    output logic [4:0] slot_o,
    output logic       sample_tick_o
);
    localparam int CNT_W = $clog2(SLOT_CNT) + 4;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign mclk_o        = cnt_q[1];
    assign sck_o         = cnt_q[3];
    assign lrck_o        = cnt_q[CNT_W-1];
    assign slot_o        = cnt_q[CNT_W-1:4];
    assign sample_tick_o = (cnt_q[3:0] == SAMPLE_PHASE);
endmodule

// File: rtl/audio_rx_deserializer.sv
// I2S ADC capture: clocks, 2-flop sync, slot deserializer, 1-entry buffer.
// Optional peak level meter enabled by AUDIO_RX_LEVEL_EN.
module audio_rx_deserializer
    import audio_pkg::*;
#(
    parameter int LEVEL_WIN_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        audio_sdout,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic [15:0] sample_left,
    output logic [15:0] sample_right,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [2:0]  level
);
    logic [4:0] slot;
    logic       sample_tick;

    audio_clk_gen u_clk_gen (
        .clk          (clk),
        .rst          (rst),
        .mclk_o       (audio_mclk),
        .lrck_o       (audio_lrck),
        .sck_o        (audio_sck),
        .slot_o       (slot),
        .sample_tick_o(sample_tick)
    );

    logic               sync1_q, sync2_q;
    sample_t            lsr_q, lsr_d;
    logic [AUDIO_W-2:0] rsr_q, rsr_d;
    logic               primed_q, primed_d;
    pair_t              buf_q, buf_d, pair_new;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               pair_done, load, drop;

    always_comb begin
        lsr_d     = lsr_q;
        rsr_d     = rsr_q;
        primed_d  = primed_q;
        pair_done = 1'b0;
        pair_new  = '{left: lsr_q, right: {rsr_q, sync2_q}};
        if (sample_tick) begin
            if (slot == SLOT_RLSB)
                pair_done = primed_q;
            else if (slot >= SLOT_LMSB && slot < SLOT_RMSB)
                lsr_d = {lsr_q[AUDIO_W-2:0], sync2_q};
            else
                rsr_d = {rsr_q[AUDIO_W-3:0], sync2_q};
            // frame 0 becomes usable once its last right bit has arrived
            if (slot == 5'(SLOT_CNT - 1))
                primed_d = 1'b1;
        end
    end

    assign load = pair_done && (!valid_q || sample_ready);
    assign drop = pair_done && valid_q && !sample_ready;

    always_comb begin
        buf_d   = buf_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (valid_q && sample_ready)
            valid_d = 1'b0;
        if (load) begin
            buf_d   = pair_new;
            valid_d = 1'b1;
        end
        if (overrun_clr)
            ovr_d = 1'b0;
        if (drop)
            ovr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            lsr_q    <= '0;
            rsr_q    <= '0;
            primed_q <= 1'b0;
            buf_q    <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sync1_q  <= audio_sdout;
            sync2_q  <= sync1_q;
            lsr_q    <= lsr_d;
            rsr_q    <= rsr_d;
            primed_q <= primed_d;
            buf_q    <= buf_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_left  = buf_q.left;
    assign sample_right = buf_q.right;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

`ifdef AUDIO_RX_LEVEL_EN
    logic [AUDIO_W-2:0]        mag_l, mag_r, mag;
    logic [AUDIO_W-2:0]        peak_q, peak_d;
    logic [LEVEL_WIN_LOG2-1:0] win_q, win_d;
    logic [2:0]                level_q, level_d;

    assign mag_l = sat_abs(pair_new.left);
    assign mag_r = sat_abs(pair_new.right);
    assign mag   = (mag_l > mag_r) ? mag_l : mag_r;

    always_comb begin
        peak_d  = peak_q;
        win_d   = win_q;
        level_d = level_q;
        if (pair_done) begin
            peak_d = (mag > peak_q) ? mag : peak_q;
            win_d  = win_q + LEVEL_WIN_LOG2'(1);
            if (&win_q) begin
                level_d = peak_d[AUDIO_W-2:AUDIO_W-4];
                peak_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q  <= '0;
            win_q   <= '0;
            level_q <= '0;
        end else begin
            peak_q  <= peak_d;
            win_q   <= win_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    logic unused_win;
    assign unused_win = ^LEVEL_WIN_LOG2;
    assign level = 3'd0;
`endif
endmodule

// File: tb/tb_audio_rx_deserializer.sv
// Self-checking bench for audio_rx_deserializer: ADC pin model,
// frame-level expectation model and directed handshake scenarios.
module tb_audio_rx_deserializer;
    localparam int WIN_LOG2 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        audio_sdout = 1'b0;
    logic        sample_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck;
    logic [15:0] sample_left, sample_right;
    logic        sample_valid, overrun;
    logic [2:0]  level;

    audio_rx_deserializer #(.LEVEL_WIN_LOG2(WIN_LOG2)) dut (
        .clk         (clk),
        .rst         (rst),
        .audio_sdout (audio_sdout),
        .audio_mclk  (audio_mclk),
        .audio_lrck  (audio_lrck),
        .audio_sck   (audio_sck),
        .sample_left (sample_left),
        .sample_right(sample_right),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .level       (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-frame ADC content, indexed by global frame number
    logic [15:0] lf[256];
    logic [15:0] rf[256];

    // model state: tc = cycles into frame, fr = frames since reset
    int          tc = 0, fr = 0, gfr = 0;
    logic        ev = 0, eo = 0, mdrop;
    logic [15:0] el = 0, er = 0, pl, pr;
    logic [2:0]  elev = 0;
    int          pk = 0, wc = 0, m1, m2;
    logic        chk_en = 0;

    function automatic logic pin_bit(input int c, input int g);
        int s;
        logic [15:0] w;
        s = c / 16;
        if (s == 0) begin
            if (g == 0) return 1'b0;
            w = rf[(g - 1) % 256];
            return w[0];
        end
        if (s <= 16) begin
            w = lf[g % 256];
            return w[16 - s];
        end
        w = rf[g % 256];
        return w[32 - s];
    endfunction

    function automatic int magn(input logic [15:0] v);
        int s;
        s = int'(signed'(v));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    always @(negedge clk) audio_sdout = pin_bit(tc, gfr);

    always @(posedge clk) begin
        if (rst) begin
            tc = 0; fr = 0; ev = 0; eo = 0; el = 0; er = 0;
            elev = 0; pk = 0; wc = 0;
        end else begin
            mdrop = 0;
            if (tc == 13 && fr >= 1) begin
                pl = lf[(gfr - 1) % 256];
                pr = rf[(gfr - 1) % 256];
                if (!ev || sample_ready) begin
                    ev = 1; el = pl; er = pr;
                end else begin
                    mdrop = 1;
                end
`ifdef AUDIO_RX_LEVEL_EN
                m1 = magn(pl);
                m2 = magn(pr);
                if (m1 > pk) pk = m1;
                if (m2 > pk) pk = m2;
                wc++;
                if (wc == (1 << WIN_LOG2)) begin
                    elev = 3'(pk / 4096);
                    pk = 0;
                    wc = 0;
                end
`endif
            end else if (ev && sample_ready) begin
                ev = 0;
            end
            if (mdrop) eo = 1;
            else if (overrun_clr) eo = 0;
            tc++;
            if (tc == 512) begin
                tc = 0; fr++; gfr++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid", sample_valid, ev);
            if (ev) begin
                check("left", sample_left, el);
                check("right", sample_right, er);
            end
            check("overrun", overrun, eo);
            check("level", level, elev);
            check("sck", audio_sck, (tc >> 3) & 1);
            check("mclk", audio_mclk, (tc >> 1) & 1);
            check("lrck", audio_lrck, (tc >> 8) & 1);
        end
    end

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!sample_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_tc(input int target, input int lim);
        int n;
        n = 0;
        while (tc != target && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_tc_hit", tc == target, 1);
    endtask

    task automatic wait_gfr(input int target, input int lim);
        int n;
        n = 0;
        while (gfr < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("wait_gfr_hit", gfr >= target, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_left"}, sample_left, 0);
        check({tag, "_right"}, sample_right, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_level"}, level, 0);
        check({tag, "_clks"}, {audio_mclk, audio_lrck, audio_sck}, 0);
    endtask

    int n, k;

    initial begin
        for (int i = 0; i < 256; i++) begin
            if (i < 3) begin
                lf[i] = 16'h1234; rf[i] = 16'hABCD;
            end else if (i < 20) begin
                lf[i] = 16'h0100 + 16'(i);
                rf[i] = 16'h8000 + 16'(i) * 16'h0111;
            end else if (i < 32) begin
                lf[i] = 16'h8000; rf[i] = 16'h0000;
            end else begin
                lf[i] = 16'h0000; rf[i] = 16'h0000;
            end
        end

        rst = 1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check_reset_vals("por");
        rst = 0;

        // first pair: frame 0 data, valid at cnt 0x20E after release
        wait_valid(2000, n);
        check("first_latency", n, 526);
        check("first_left", sample_left, 16'h1234);
        check("first_right", sample_right, 16'hABCD);

        // ready held: one valid per frame, no overrun
        sample_ready = 1;
        k = 0;
        repeat (2048) begin
            @(negedge clk);
            if (sample_valid) k++;
        end
        check("valids_in_4_frames", k, 4);
        check("stream_ovr", overrun, 0);

        // stall 3 frames: first pair kept, later ones dropped
        sample_ready = 0;
        repeat (1536) @(negedge clk);
        check("stall_valid", sample_valid, 1);
        check("stall_left", sample_left, 16'h0104);
        check("stall_right", sample_right, 16'h8444);
        check("stall_ovr", overrun, 1);
        overrun_clr = 1;
        @(negedge clk);
        overrun_clr = 0;
        check("ovr_cleared", overrun, 0);

        // accept in the completion cycle while full
        wait_tc(13, 1200);
        sample_ready = 1;
        @(negedge clk);
        sample_ready = 0;
        check("swap_valid", sample_valid, 1);
        check("swap_ovr", overrun, 0);
        check("swap_left", sample_left, 16'h0108);
        check("swap_right", sample_right, 16'h8888);

        // reset mid-frame at slot 10, then re-prime
        wait_tc(160, 1200);
        rst = 1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 0;
        wait_valid(2000, n);
        check("reprime_latency", n, 526);
        check("reprime_left", sample_left, 16'h0109);
        check("reprime_right", sample_right, 16'h8999);

        // level meter: full-scale negative left, then silence
        sample_ready = 1;
        wait_gfr(30, 20000);
`ifdef AUDIO_RX_LEVEL_EN
        check("level_fullscale", level, 7);
`else
        check("level_fullscale", level, 0);
`endif
        wait_gfr(48, 20000);
        check("level_silence", level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
